// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Instruction-memory request/response bundle used by the fetch PC unit.
//   master : the fetch unit (drives req/addr, receives addr_ok/data_ok/rdata)
//   slave  : the instruction memory
// Signals
//   req      request valid
//   addr     request address (word aligned when req is high)
//   addr_ok  request accepted this cycle
//   data_ok  response valid this cycle (in order, at least one cycle after addr_ok)
//   rdata    response instruction word
interface fetch_pc_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  addr_ok,
    input  data_ok,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output addr_ok,
    output data_ok,
    output rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Holds the architectural fetch PC, issues one instruction fetch at a time over
//   the imem handshake and presents {pcF, instrF, validF, adelF} to the F/D register.
//   A one-entry skid buffer absorbs decode stalls; flush discards everything fetched
//   or in flight and restarts at pc_new.
// Ports
//   clk       clock, all state on posedge
//   resetn    asynchronous active-low reset
//   pc_new    next PC from PC-select, taken on every accepted request and on flush
//   flush     redirect: drop presented/buffered/in-flight work, restart at pc_new
//   stall     F/D register cannot take the presented slot this cycle
//   imem      instruction-memory bundle (master side)
//   pcplus4F  pc + 4 back to PC-select
//   pcF       PC of the presented slot
//   instrF    presented instruction
//   validF    presented slot is valid
//   adelF     presented slot is an address-error marker (misaligned PC)
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            pc_new,
  input  logic                   flush,
  input  logic                   stall,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            pcplus4F,
  output logic [31:0]            pcF,
  output logic [31:0]            instrF,
  output logic                   validF,
  output logic                   adelF
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic        drop_reg, drop_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_inflight_reg;
  logic        skid_full_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] skid_instr_reg;

  logic busy;
  logic can_issue;
  logic req;
  logic accept;
  logic deliver;
  logic misaligned;
  logic consumed;
  logic out_free;

  always_comb begin
    busy       = skid_full_reg | (validF & stall);
    can_issue  = (state_reg == S_REQ) & ~busy & ~flush;
    // Gated by resetn so no request escapes while reset is held.
    req        = can_issue & (pc_reg[1:0] == 2'b00) & resetn;
    accept     = req & imem.addr_ok;
    deliver    = (state_reg == S_WAIT) & imem.data_ok & ~drop_reg & ~flush;
    misaligned = can_issue & (pc_reg[1:0] != 2'b00);
    consumed   = validF & ~stall;
    out_free   = ~validF | consumed;

    state_next = state_reg;
    drop_next  = drop_reg;
    if (flush) begin
      // Anything the memory still owes us must be swallowed when it arrives.
      if (((state_reg == S_WAIT) & ~imem.data_ok) | ((state_reg == S_REQ) & imem.addr_ok)) begin
        drop_next  = 1'b1;
        state_next = S_WAIT;
      end else begin
        drop_next  = 1'b0;
        state_next = S_REQ;
      end
    end else begin
      case (state_reg)
        S_REQ: begin
          if (accept) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem.data_ok) begin
            drop_next  = 1'b0;
            state_next = S_REQ;
          end
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  assign imem.req  = req;
  assign imem.addr = pc_reg;
  assign pcplus4F  = pc_reg + 32'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_REQ;
      drop_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      drop_reg  <= drop_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg          <= RESET_PC;
      pc_inflight_reg <= 32'd0;
      skid_full_reg   <= 1'b0;
      skid_pc_reg     <= 32'd0;
      skid_instr_reg  <= 32'd0;
      pcF             <= 32'd0;
      instrF          <= 32'd0;
      validF          <= 1'b0;
      adelF           <= 1'b0;
    end else begin
      if (accept) pc_inflight_reg <= pc_reg;
      if (flush || accept) pc_reg <= pc_new;

      if (flush) begin
        validF        <= 1'b0;
        adelF         <= 1'b0;
        skid_full_reg <= 1'b0;
      end else if (misaligned) begin
        // Re-presented every cycle it is free, so it stays put until a flush.
        pcF    <= pc_reg;
        instrF <= 32'd0;
        adelF  <= 1'b1;
        validF <= 1'b1;
      end else if (deliver) begin
        if (out_free && !skid_full_reg) begin
          pcF    <= pc_inflight_reg;
          instrF <= imem.rdata;
          adelF  <= 1'b0;
          validF <= 1'b1;
        end else begin
          // Keep order: an older skid entry leaves first, the new response waits.
          skid_pc_reg    <= pc_inflight_reg;
          skid_instr_reg <= imem.rdata;
          skid_full_reg  <= 1'b1;
          if (consumed) begin
            pcF    <= skid_pc_reg;
            instrF <= skid_instr_reg;
            adelF  <= 1'b0;
          end
        end
      end else if (consumed) begin
        if (skid_full_reg) begin
          pcF           <= skid_pc_reg;
          instrF        <= skid_instr_reg;
          adelF         <= 1'b0;
          skid_full_reg <= 1'b0;
        end else begin
          validF <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        use_redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] pc_new;
  logic [31:0] pcplus4F, pcF, instrF;
  logic        validF, adelF;

  // memory model controls
  logic        ready = 1'b1;
  logic        ghost_acc = 1'b0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  logic        q_adel[$];
  int          q_cyc[$];

  fetch_pc_unit_if imem ();

  fetch_pc_unit #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pc_new   (pc_new),
    .flush    (flush),
    .stall    (stall),
    .imem     (imem),
    .pcplus4F (pcplus4F),
    .pcF      (pcF),
    .instrF   (instrF),
    .validF   (validF),
    .adelF    (adelF)
  );

  always #5 clk = ~clk;

  // PC-select stand-in: sequential unless the bench redirects.
  assign pc_new = use_redirect ? redirect_pc : pcplus4F;

  // Memory contents: instruction = address ^ 0x9BC8_0001 (so 0xBFC0_0000 -> 0x2408_0001).
  assign imem.addr_ok = ready;
  assign imem.data_ok = pend && (cnt == 0);
  assign imem.rdata   = paddr ^ 32'h9BC8_0001;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      pend <= 1'b0;
    end else if (imem.addr_ok && (imem.req || ghost_acc)) begin
      pend  <= 1'b1;
      paddr <= imem.addr;
      cnt   <= lat - 1;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end

  // One line per slot taken by the F/D register.
  always @(negedge clk) begin
    if (resetn && validF && !stall) begin
      q_pc.push_back(pcF);
      q_ins.push_back(instrF);
      q_adel.push_back(adelF);
      q_cyc.push_back(cyc);
      $display("fetch  cyc=%0d pc=%h instr=%h adel=%0d", cyc, pcF, instrF, adelF);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    @(negedge clk);
    while (!imem.req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!imem.req) check_val(tag, {31'd0, imem.req}, 32'd1);
  endtask

  task automatic wait_pend(input string tag);
    int n = 0;
    @(negedge clk);
    while (!pend && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!pend) check_val(tag, {31'd0, pend}, 32'd1);
  endtask

  task automatic wait_recs(input string tag, input int want);
    int n = 0;
    while (q_pc.size() < want && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q_pc.size() < want) check_val(tag, q_pc.size(), want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] p;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_validF", {31'd0, validF}, 32'd0);
    check_val("rst_adelF", {31'd0, adelF}, 32'd0);
    check_val("rst_pcF", pcF, 32'd0);
    check_val("rst_instrF", instrF, 32'd0);
    check_val("rst_req", {31'd0, imem.req}, 32'd0);
    check_val("rst_addr", imem.addr, 32'hBFC0_0000);
    check_val("rst_pcplus4", pcplus4F, 32'hBFC0_0004);

    // ---- 1: release, first fetch ----
    resetn = 1'b1;
    #1;
    check_val("t1_req", {31'd0, imem.req}, 32'd1);
    check_val("t1_addr", imem.addr, 32'hBFC0_0000);
    @(negedge clk);
    check_val("t1_pc_adv", pcplus4F, 32'hBFC0_0008);
    check_val("t1_addr_adv", imem.addr, 32'hBFC0_0004);
    check_val("t1_wait_noreq", {31'd0, imem.req}, 32'd0);

    // ---- 2: streaming ----
    wait_recs("t2_wait", 3);
    check_val("t2_pc0", q_pc[0], 32'hBFC0_0000);
    check_val("t2_ins0", q_ins[0], 32'h2408_0001);
    check_val("t2_pc1", q_pc[1], 32'hBFC0_0004);
    check_val("t2_ins1", q_ins[1], 32'h2408_0005);
    check_val("t2_pc2", q_pc[2], 32'hBFC0_0008);
    check_val("t2_ins2", q_ins[2], 32'h2408_0009);
    check_val("t2_gap01", q_cyc[1] - q_cyc[0], 32'd2);
    check_val("t2_gap12", q_cyc[2] - q_cyc[1], 32'd2);

    // ---- 3: stall across a response ----
    wait_pend("t3_pend");
    n = q_pc.size();
    p = 32'hBFC0_0000 + 32'(4 * n);
    drive_edge();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t3_hold_valid", {31'd0, validF}, 32'd1);
      check_val("t3_hold_pc", pcF, p);
      check_val("t3_hold_ins", instrF, p ^ 32'h9BC8_0001);
      check_val("t3_noreq", {31'd0, imem.req}, 32'd0);
    end
    drive_edge();
    stall = 1'b0;
    wait_recs("t3_wait", n + 3);
    check_val("t3_rel_pc", q_pc[n], p);
    check_val("t3_next_pc", q_pc[n + 1], p + 32'd4);
    check_val("t3_next2_pc", q_pc[n + 2], p + 32'd8);

    // ---- 4: flush while waiting, response two cycles later ----
    drive_edge();
    lat = 3;
    wait_req("t4_req");
    drive_edge();
    n = q_pc.size();
    flush = 1'b1;
    use_redirect = 1'b1;
    redirect_pc = 32'h8000_0180;
    @(negedge clk);
    check_val("t4_flush_noreq", {31'd0, imem.req}, 32'd0);
    drive_edge();
    flush = 1'b0;
    use_redirect = 1'b0;
    lat = 1;
    @(negedge clk);
    check_val("t4_valid0", {31'd0, validF}, 32'd0);
    check_val("t4_noreq", {31'd0, imem.req}, 32'd0);
    check_val("t4_addr", imem.addr, 32'h8000_0180);
    @(negedge clk);
    check_val("t4_valid0_b", {31'd0, validF}, 32'd0);
    wait_recs("t4_wait", n + 1);
    check_val("t4_pc", q_pc[n], 32'h8000_0180);
    check_val("t4_ins", q_ins[n], 32'h1BC8_0181);

    // ---- 5: flush in the cycle the request is accepted ----
    drive_edge();
    ready = 1'b0;
    wait_req("t5_req");
    drive_edge();
    n = q_pc.size();
    flush = 1'b1;
    ghost_acc = 1'b1;
    ready = 1'b1;
    use_redirect = 1'b1;
    redirect_pc = 32'h9000_0000;
    @(negedge clk);
    check_val("t5_flush_noreq", {31'd0, imem.req}, 32'd0);
    drive_edge();
    flush = 1'b0;
    ghost_acc = 1'b0;
    use_redirect = 1'b0;
    @(negedge clk);
    check_val("t5_valid0", {31'd0, validF}, 32'd0);
    check_val("t5_drop_noreq", {31'd0, imem.req}, 32'd0);
    @(negedge clk);
    check_val("t5_req_new", {31'd0, imem.req}, 32'd1);
    check_val("t5_addr_new", imem.addr, 32'h9000_0000);
    wait_recs("t5_wait", n + 1);
    check_val("t5_pc", q_pc[n], 32'h9000_0000);
    check_val("t5_ins", q_ins[n], 32'h0BC8_0001);

    // ---- 6: misaligned pc_new ----
    drive_edge();
    ready = 1'b0;
    wait_req("t6_req");
    drive_edge();
    use_redirect = 1'b1;
    redirect_pc = 32'hBFC0_0002;
    ready = 1'b1;
    drive_edge();
    use_redirect = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(validF && adelF) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("t6_adel", {31'd0, adelF}, 32'd1);
    check_val("t6_pc", pcF, 32'hBFC0_0002);
    check_val("t6_ins", instrF, 32'd0);
    check_val("t6_noreq", {31'd0, imem.req}, 32'd0);
    drive_edge();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t6_hold_valid", {31'd0, validF}, 32'd1);
      check_val("t6_hold_pc", pcF, 32'hBFC0_0002);
      check_val("t6_hold_noreq", {31'd0, imem.req}, 32'd0);
    end
    drive_edge();
    stall = 1'b0;
    ready = 1'b0;
    flush = 1'b1;
    use_redirect = 1'b1;
    redirect_pc = 32'hBFC0_0010;
    @(negedge clk);
    check_val("t6_flush_noreq", {31'd0, imem.req}, 32'd0);
    drive_edge();
    flush = 1'b0;
    use_redirect = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check_val("t6_clr_valid", {31'd0, validF}, 32'd0);
    check_val("t6_clr_adel", {31'd0, adelF}, 32'd0);
    check_val("t6_restart_req", {31'd0, imem.req}, 32'd1);
    check_val("t6_restart_addr", imem.addr, 32'hBFC0_0010);
    q_pc.delete();
    q_ins.delete();
    q_adel.delete();
    q_cyc.delete();
    wait_recs("t6_wait", 1);
    check_val("t6_after_pc", q_pc[0], 32'hBFC0_0010);
    check_val("t6_after_ins", q_ins[0], 32'h2408_0011);
    check_val("t6_after_adel", {31'd0, q_adel[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
